sub_scoreboard: RTL and testbench
=================================

// Module: sub_scoreboard
// PURPOSE
//  Downstream checker for sub_mon. Compares the monitor's model result (o_mon_o) against the
//  registered DUT result (o_dtm_o) over a fixed-length run. Counts samples and mismatches,
//  captures the first mismatch, and issues a pass/fail verdict against an error budget.
//  Sits at the end of the arithmetic testbench chain: driver -> DUT/sub_mon -> sub_scoreboard.
// PARAMETERS
//  WIDTH      32    data width; matches sub_mon WIDTH
//  N_SAMPLES  1024  valid samples accepted per run; 1 <= N_SAMPLES <= 2**CNT_W-1
//  MAX_ERR    0     largest mismatch count that still passes
//  CNT_W      16    width of the sample, error and index counters
// PORTS
//  clk          in   1      clock; all logic is on the rising edge
//  reset        in   1      asynchronous, active-high reset
//  i_start      in   1      single-cycle pulse that starts a run (acted on in IDLE/DONE)
//  i_valid      in   1      i_mon_o/i_dtm_o hold a valid pair this cycle (driver delays by 1 to align with sub_mon)
//  i_mon_o      in   WIDTH  expected value from sub_mon
//  i_dtm_o      in   WIDTH  actual value (DUT output as registered by sub_mon)
//  o_busy       out  1      state is RUN or DRAIN
//  o_done       out  1      state is DONE; verdict and counters are final
//  o_pass       out  1      valid only when o_done=1: err_cnt <= MAX_ERR
//  o_smp_cnt    out  CNT_W  samples accepted this run
//  o_err_cnt    out  CNT_W  mismatches counted this run
//  o_first_vld  out  1      a mismatch has been captured
//  o_first_idx  out  CNT_W  0-based sample index of the first mismatch
//  o_first_exp  out  WIDTH  i_mon_o value of the first mismatch
//  o_first_act  out  WIDTH  i_dtm_o value of the first mismatch
// BEHAVIOUR
//  - Reset: state=IDLE; every output, counter and pipeline register is 0. Reset can land mid-run;
//    it aborts the run immediately and discards in-flight samples.
//  - FSM: IDLE -i_start-> RUN; RUN -(N_SAMPLES-th accept)-> DRAIN; DRAIN -(after 2 cycles)-> DONE;
//    DONE -i_start-> RUN. i_start in RUN or DRAIN is ignored.
//  - Entry to RUN clears smp/err counters and o_first_*. o_done and o_pass drop in the same cycle.
//  - Accept: i_valid=1 while state=RUN and accepted count < N_SAMPLES. i_valid outside RUN is ignored.
//    i_valid may have gaps of any length.
//  - Pipeline, 2 stages:
//      S1 registers valid, idx = accept count, mon, dtm, and mis = (mon != dtm).
//      S2 updates the counters and the first-mismatch capture.
//    Counters and o_first_* reflect an accepted sample 2 cycles after its accept edge.
//  - o_smp_cnt counts in S2. o_err_cnt += S2.mis. First mismatch: if S2.mis and !o_first_vld,
//    load idx/mon/dtm and set o_first_vld. Later mismatches never overwrite the capture.
//  - DRAIN exists so the last accepted sample reaches S2 before DONE. On entry to DONE,
//    o_smp_cnt = N_SAMPLES and o_pass is registered once.
//  - Arithmetic is unsigned. N_SAMPLES fits CNT_W, so counters cannot wrap (no saturation logic).
//  - i_start and the final accept in the same cycle in RUN: i_start is ignored.
// STRUCTURE
//  - arith_tb_pkg (shared): FSM state localparams (IDLE=0, RUN=1, DRAIN=2, DONE=3) and the
//    DRAIN_CYC=2 constant.
//  - Sub-module sub_sb_cmp: S1 register stage plus comparator (valid/idx/mon/dtm/mis).
//    FSM, counters and capture logic stay in the top module.
// TESTING
//  1 Reset with outputs nonzero (mid-run) -> all outputs 0, o_busy=0, o_done=0 on the same edge.
//  2 N_SAMPLES=4, MAX_ERR=0; 4 pairs mon=dtm=0x10 -> o_done 3 cycles after the last valid;
//    smp=4, err=0, pass=1, first_vld=0.
//  3 N_SAMPLES=4; idx2 mon=0x5/dtm=0x8, idx3 mon=0x1/dtm=0x2 -> err=2, pass=0, first_idx=2,
//    first_exp=0x5, first_act=0x8.
//  4 MAX_ERR=1, one mismatch in 4 -> pass=1. Valid asserted in IDLE and DONE -> counts unchanged.
//    Valid every 3rd cycle -> same verdict.
//  5 i_start during RUN after 2 accepts -> ignored, run continues. Reset after 2 accepts,
//    then i_start -> fresh run, smp ends at 4.
//  6 From DONE (err=2), i_start -> cycle after: smp=0, err=0, first_vld=0, done=0, busy=1.

Source files
------------

// File: rtl/arith_tb_pkg.sv
// Shared definitions for the arithmetic testbench chain: scoreboard FSM states and drain depth.
package arith_tb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Cycles spent in DRAIN so the last accepted sample clears both pipeline stages.
  localparam int DRAIN_CYC = 2;

endpackage

// File: rtl/sub_sb_cmp.sv
// First scoreboard stage: registers an accepted pair with its sample index and flags a mismatch.
module sub_sb_cmp #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_vld,
  input  logic [CNT_W-1:0] in_idx,
  input  logic [WIDTH-1:0] in_mon,
  input  logic [WIDTH-1:0] in_dtm,
  output logic             s1_vld,
  output logic [CNT_W-1:0] s1_idx,
  output logic [WIDTH-1:0] s1_mon,
  output logic [WIDTH-1:0] s1_dtm,
  output logic             s1_mis
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld <= 1'b0;
      s1_idx <= '0;
      s1_mon <= '0;
      s1_dtm <= '0;
      s1_mis <= 1'b0;
    end else begin
      s1_vld <= in_vld;
      // mis is qualified by valid so stale payload never counts as an error
      s1_mis <= in_vld && (in_mon != in_dtm);
      if (in_vld) begin
        s1_idx <= in_idx;
        s1_mon <= in_mon;
        s1_dtm <= in_dtm;
      end
    end
  end

endmodule

// File: rtl/sub_scoreboard.sv
// End-of-chain checker: compares model vs DUT results over a fixed-length run and issues a verdict.
module sub_scoreboard
  import arith_tb_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int N_SAMPLES = 1024,
  parameter int MAX_ERR   = 0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_mon_o,
  input  logic [WIDTH-1:0] i_dtm_o,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [CNT_W-1:0] o_smp_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_first_vld,
  output logic [CNT_W-1:0] o_first_idx,
  output logic [WIDTH-1:0] o_first_exp,
  output logic [WIDTH-1:0] o_first_act
);

  localparam logic [CNT_W-1:0] ACC_LAST   = CNT_W'(N_SAMPLES - 1);
  localparam logic [CNT_W-1:0] ERR_LIM    = CNT_W'(MAX_ERR);
  localparam logic [1:0]       DRAIN_LAST = 2'(DRAIN_CYC - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] acc_cnt;
  logic [1:0]       drain_cnt;
  logic             start_run, accept, to_done;

  logic             s1_vld, s1_mis;
  logic [CNT_W-1:0] s1_idx;
  logic [WIDTH-1:0] s1_mon, s1_dtm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_run = 1'b0;
    accept    = 1'b0;
    to_done   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (i_start) begin
          start_run = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // RUN is left on the final accept, so acc_cnt < N_SAMPLES holds throughout
        if (i_valid) begin
          accept = 1'b1;
          if (acc_cnt == ACC_LAST) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          to_done   = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      if (start_run)   acc_cnt <= '0;
      else if (accept) acc_cnt <= acc_cnt + 1'b1;
      if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
      else                drain_cnt <= '0;
    end
  end

  sub_sb_cmp #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cmp (
    .clk    (clk),
    .reset  (reset),
    .in_vld (accept),
    .in_idx (acc_cnt),
    .in_mon (i_mon_o),
    .in_dtm (i_dtm_o),
    .s1_vld (s1_vld),
    .s1_idx (s1_idx),
    .s1_mon (s1_mon),
    .s1_dtm (s1_dtm),
    .s1_mis (s1_mis)
  );

  // Second stage: counters, first-mismatch capture and the verdict
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_smp_cnt   <= '0;
      o_err_cnt   <= '0;
      o_first_vld <= 1'b0;
      o_first_idx <= '0;
      o_first_exp <= '0;
      o_first_act <= '0;
      o_pass      <= 1'b0;
    end else if (start_run) begin
      o_smp_cnt   <= '0;
      o_err_cnt   <= '0;
      o_first_vld <= 1'b0;
      o_first_idx <= '0;
      o_first_exp <= '0;
      o_first_act <= '0;
      o_pass      <= 1'b0;
    end else begin
      if (s1_vld) begin
        o_smp_cnt <= o_smp_cnt + 1'b1;
        o_err_cnt <= o_err_cnt + CNT_W'(s1_mis);
        if (s1_mis && !o_first_vld) begin
          o_first_vld <= 1'b1;
          o_first_idx <= s1_idx;
          o_first_exp <= s1_mon;
          o_first_act <= s1_dtm;
        end
      end
      // err_cnt is final here: the last sample left S2 during the first DRAIN cycle
      if (to_done) o_pass <= (o_err_cnt <= ERR_LIM);
    end
  end

  assign o_busy = (state == RUN) || (state == DRAIN);
  assign o_done = (state == DONE);

endmodule

// File: tb/tb_sub_scoreboard.sv
// Randomized scoreboard bench: two scoreboards (MAX_ERR 0 and 1) share stimulus; results checked at o_done.
module tb_sub_scoreboard;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int CW = 16;

  logic clk = 1'b0, reset = 1'b1, i_start = 1'b0, i_valid = 1'b0;
  logic [W-1:0] i_mon_o = '0, i_dtm_o = '0;

  logic [1:0]    busy, done, pass, fv;
  logic [CW-1:0] smp[2], err[2], fi[2];
  logic [W-1:0]  fe[2], fa[2];

  int vectors = 0, errs = 0;

  typedef struct {
    logic [CW-1:0] smp, err, fi;
    logic          fv;
    logic [W-1:0]  fe, fa;
    logic [1:0]    p;
  } exp_t;
  exp_t exq[$];
  exp_t cur, last_exp;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sub_scoreboard #(.WIDTH(W), .N_SAMPLES(N), .MAX_ERR(g), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .i_start(i_start), .i_valid(i_valid),
      .i_mon_o(i_mon_o), .i_dtm_o(i_dtm_o),
      .o_busy(busy[g]), .o_done(done[g]), .o_pass(pass[g]),
      .o_smp_cnt(smp[g]), .o_err_cnt(err[g]), .o_first_vld(fv[g]),
      .o_first_idx(fi[g]), .o_first_exp(fe[g]), .o_first_act(fa[g]));
  end

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: scan the accepted pairs for mismatches
  function automatic exp_t model(input logic [W-1:0] m[$], input logic [W-1:0] d[$]);
    exp_t e;
    int n = 0;
    e = '{default: '0};
    for (int i = 0; i < N; i++)
      if (m[i] != d[i]) begin
        if (!e.fv) begin
          e.fv = 1'b1; e.fi = CW'(i); e.fe = m[i]; e.fa = d[i];
        end
        n++;
      end
    e.smp  = CW'(N);
    e.err  = CW'(n);
    e.p[0] = (n <= 0);
    e.p[1] = (n <= 1);
    return e;
  endfunction

  // Monitor: compare against the scoreboard queue on each rising o_done
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (done[0] && !prev_done) begin
      if (exq.size() == 0) begin
        vectors++; errs++;
        $display("FAIL unexpected_done: actual 1 required 0 at %0t", $time);
      end else begin
        cur = exq.pop_front();
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("done%0d", k), done[k], 1'b1);
          chk($sformatf("smp%0d", k), smp[k], cur.smp);
          chk($sformatf("err%0d", k), err[k], cur.err);
          chk($sformatf("pass%0d", k), pass[k], cur.p[k]);
          chk($sformatf("first_vld%0d", k), fv[k], cur.fv);
          if (cur.fv) begin
            chk($sformatf("first_idx%0d", k), fi[k], cur.fi);
            chk($sformatf("first_exp%0d", k), fe[k], cur.fe);
            chk($sformatf("first_act%0d", k), fa[k], cur.fa);
          end
        end
      end
    end
    prev_done = done[0];
  end

  task automatic chk_zero(input string nm);
    for (int k = 0; k < 2; k++) begin
      chk({nm, "_busy"}, busy[k], 0); chk({nm, "_done"}, done[k], 0);
      chk({nm, "_pass"}, pass[k], 0); chk({nm, "_smp"}, smp[k], 0);
      chk({nm, "_err"}, err[k], 0);   chk({nm, "_fv"}, fv[k], 0);
      chk({nm, "_fi"}, fi[k], 0);     chk({nm, "_fe"}, fe[k], 0);
      chk({nm, "_fa"}, fa[k], 0);
    end
  endtask

  task automatic rand_pairs(output logic [W-1:0] m[$], output logic [W-1:0] d[$], input int pct);
    logic [W-1:0] v;
    m = {}; d = {};
    for (int i = 0; i < N; i++) begin
      v = $urandom;
      m.push_back(v);
      d.push_back(($urandom_range(0, 99) < pct) ? (v ^ (32'h1 << $urandom_range(0, 31))) : v);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
  endtask

  // Drives one run; gap<0 means random gaps of 0..3 idle cycles
  task automatic run(input logic [W-1:0] m[$], input logic [W-1:0] d[$], input int gap,
                     input bit do_start, input bit start_mid, input bit start_last);
    int g;
    bit seen;
    if (do_start) pulse_start();
    for (int i = 0; i < N; i++) begin
      g = (gap < 0) ? $urandom_range(0, 3) : gap;
      repeat (g) @(negedge clk);
      i_valid = 1'b1; i_mon_o = m[i]; i_dtm_o = d[i];
      i_start = (start_mid && i == 2) || (start_last && i == N - 1);
      @(negedge clk);
      i_valid = 1'b0; i_start = 1'b0;
      if (start_mid && i == 2) chk("busy_after_mid_start", busy[0], 1);
    end
    last_exp = model(m, d);
    exq.push_back(last_exp);
    @(negedge clk);
    chk("drain_not_done", done[0], 0);
    chk("drain_busy", busy[0], 1);
    @(negedge clk);
    chk("done_latency", done[0], 1);
    seen = done[0];
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      seen = done[0];
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic stray_valids(input int cyc);
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      i_valid = 1'b1; i_mon_o = $urandom; i_dtm_o = $urandom;
    end
    @(negedge clk); i_valid = 1'b0;
    @(negedge clk);
  endtask

  logic [W-1:0] m[$], d[$];

  initial begin
    #1; chk_zero("reset_init");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Valid while IDLE is ignored
    stray_valids(3);
    chk("idle_smp", smp[0], 0);
    chk("idle_busy", busy[0], 0);

    // All-match run
    m = {32'h10, 32'h10, 32'h10, 32'h10}; d = m;
    run(m, d, 0, 1, 0, 0);

    // Valid while DONE is ignored
    stray_valids(3);
    chk("done_smp_hold", smp[0], last_exp.smp);
    chk("done_err_hold", err[0], last_exp.err);

    // Two mismatches at idx 2 and 3
    m = {32'h10, 32'h10, 32'h5, 32'h1}; d = {32'h10, 32'h10, 32'h8, 32'h2};
    run(m, d, 0, 1, 0, 0);

    // Restart from DONE clears everything on the next cycle
    pulse_start();
    for (int k = 0; k < 2; k++) begin
      chk("restart_smp", smp[k], 0); chk("restart_err", err[k], 0);
      chk("restart_fv", fv[k], 0);   chk("restart_done", done[k], 0);
      chk("restart_busy", busy[k], 1); chk("restart_pass", pass[k], 0);
    end
    rand_pairs(m, d, 40);
    run(m, d, -1, 0, 0, 0);

    // One mismatch, valid every 3rd cycle: splits the two budgets
    m = {32'hA, 32'hB, 32'hC, 32'hD}; d = {32'hA, 32'hBB, 32'hC, 32'hD};
    run(m, d, 2, 1, 0, 0);

    // i_start in RUN ignored; i_start coincident with final accept ignored
    rand_pairs(m, d, 30);
    run(m, d, 0, 1, 1, 0);
    rand_pairs(m, d, 30);
    run(m, d, -1, 1, 0, 1);
    @(negedge clk);
    chk("start_last_stays_done", done[0], 1);

    // Reset mid-run after 2 accepts aborts, then a fresh run completes
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); i_valid = 1'b1; i_mon_o = 32'h3; i_dtm_o = (i == 0) ? 32'h4 : 32'h3;
    end
    @(negedge clk); i_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_smp", smp[0], 2);
    chk("pre_reset_fv", fv[0], 1);
    #2 reset = 1'b1;
    #1 chk_zero("reset_mid");
    @(negedge clk); reset = 1'b0;
    rand_pairs(m, d, 50);
    run(m, d, -1, 1, 0, 0);

    // Randomized runs
    for (int r = 0; r < 20; r++) begin
      rand_pairs(m, d, $urandom_range(0, 60));
      run(m, d, -1, 1, 0, 0);
    end

    repeat (3) @(negedge clk);
    if (exq.size() != 0) chk("queue_drained", exq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
